// File: rtl/div_share_ctrl.sv
// Two-requester front end for one shared 8-bit sign-magnitude sequential divider.
// Round-robin grant, start/busy sequencing, divide-by-zero bypass, tagged response.
module div_share_ctrl (
   input  logic       clk,
   input  logic       rstn,
   input  logic       req0_valid,
   input  logic [7:0] req0_x,
   input  logic [7:0] req0_y,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_x,
   input  logic [7:0] req1_y,
   output logic       req1_ready,
   output logic [7:0] div_x,
   output logic [7:0] div_y,
   output logic       div_start,
   input  logic [7:0] div_z,
   input  logic [7:0] div_r,
   input  logic       div_busy,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic       rsp_id,
   output logic [7:0] rsp_z,
   output logic [7:0] rsp_r,
   output logic       rsp_err
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t     state, state_nxt;
   logic       ptr, ptr_nxt;
   logic       seen_busy, seen_busy_nxt;
   logic [7:0] op_x, op_y;
   logic       op_id;
   logic [7:0] res_z, res_r;
   logic       res_err;

   logic       grant0, grant1, accept;
   logic [7:0] acc_x, acc_y;
   logic       acc_zero;
   logic       ld_op, ld_zero, ld_div;

   // ptr names the requester that wins when both are valid
   always_comb begin
      grant0   = req0_valid & (~req1_valid | ~ptr);
      grant1   = req1_valid & (~req0_valid |  ptr);
      acc_x    = grant1 ? req1_x : req0_x;
      acc_y    = grant1 ? req1_y : req0_y;
      acc_zero = (acc_y[6:0] == 7'd0);
   end

   assign req0_ready = (state == IDLE) & grant0;
   assign req1_ready = (state == IDLE) & grant1;
   assign accept     = req0_ready | req1_ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         ptr       <= 1'b0;
         seen_busy <= 1'b0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         seen_busy <= seen_busy_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      ptr_nxt       = ptr;
      seen_busy_nxt = seen_busy;
      ld_op         = 1'b0;
      ld_zero       = 1'b0;
      ld_div        = 1'b0;
      div_start     = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               ld_op   = 1'b1;
               ptr_nxt = grant0;
               if (acc_zero) begin
                  ld_zero   = 1'b1;
                  state_nxt = RESP;
               end else begin
                  state_nxt = ISSUE;
               end
            end
         end
         ISSUE: begin
            div_start     = 1'b1;
            seen_busy_nxt = 1'b0;
            state_nxt     = WAIT;
         end
         WAIT: begin
            // busy may not rise until a cycle after start; only a low after high means done
            if (div_busy) begin
               seen_busy_nxt = 1'b1;
            end else if (seen_busy) begin
               ld_div    = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         op_x  <= 8'h00;
         op_y  <= 8'h00;
         op_id <= 1'b0;
      end else if (ld_op) begin
         op_x  <= acc_x;
         op_y  <= acc_y;
         op_id <= grant1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         res_z   <= 8'h00;
         res_r   <= 8'h00;
         res_err <= 1'b0;
      end else if (ld_zero) begin
         res_z   <= {acc_x[7] ^ acc_y[7], 7'h7F};
         res_r   <= acc_x;
         res_err <= 1'b1;
      end else if (ld_div) begin
         res_z   <= div_z;
         res_r   <= div_r;
         res_err <= 1'b0;
      end
   end

   assign div_x     = op_x;
   assign div_y     = op_y;
   assign rsp_valid = (state == RESP);
   assign rsp_id    = op_id;
   assign rsp_z     = res_z;
   assign rsp_r     = res_r;
   assign rsp_err   = res_err;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Bench for div_share_ctrl: behavioural 8-cycle divider, vector table, scoreboard
// queue fed at accept and drained at the response handshake, plus corner sequences.
module tb_div_share_ctrl;

   typedef struct packed {
      logic       id;
      logic [7:0] z;
      logic [7:0] r;
      logic       err;
   } rsp_t;

   typedef struct {
      bit         id;
      logic [7:0] x;
      logic [7:0] y;
      logic [7:0] z;
      logic [7:0] r;
      logic       err;
   } vec_t;

   logic       clk = 1'b0;
   logic       rstn;
   logic       req0_valid, req1_valid, req0_ready, req1_ready;
   logic [7:0] req0_x, req0_y, req1_x, req1_y;
   logic [7:0] div_x, div_y, div_z, div_r;
   logic       div_start, div_busy;
   logic       rsp_valid, rsp_ready, rsp_id, rsp_err;
   logic [7:0] rsp_z, rsp_r;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   starts = 0;
   bit   late = 1'b0;
   rsp_t sbq[$];
   bit   grants[$];

   always #5 clk = ~clk;

   div_share_ctrl dut (
      .clk(clk), .rstn(rstn),
      .req0_valid(req0_valid), .req0_x(req0_x), .req0_y(req0_y), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_x(req1_x), .req1_y(req1_y), .req1_ready(req1_ready),
      .div_x(div_x), .div_y(div_y), .div_start(div_start),
      .div_z(div_z), .div_r(div_r), .div_busy(div_busy),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_z(rsp_z), .rsp_r(rsp_r), .rsp_err(rsp_err)
   );

   function automatic rsp_t ref_div(input logic id, input logic [7:0] x, input logic [7:0] y);
      rsp_t e;
      e.id = id;
      if (y[6:0] == 7'd0) begin
         e.z = {x[7] ^ y[7], 7'h7F};
         e.r = x;
         e.err = 1'b1;
      end else begin
         e.z = {x[7] ^ y[7], 7'(x[6:0] / y[6:0])};
         e.r = {x[7], 7'(x[6:0] % y[6:0])};
         e.err = 1'b0;
      end
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // divider model: busy for 8 cycles starting the cycle after start (one later when late=1)
   int         busy_cnt;
   bit         pend;
   logic [7:0] lx, ly;
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         div_busy <= 1'b0; busy_cnt <= 0; pend <= 1'b0;
         div_z <= 8'h00; div_r <= 8'h00; lx <= 8'h00; ly <= 8'h01;
      end else if (div_start) begin
         lx <= div_x; ly <= div_y;
         div_z <= 8'hEE; div_r <= 8'hEE;
         if (late) pend <= 1'b1;
         else begin div_busy <= 1'b1; busy_cnt <= 8; end
      end else if (pend) begin
         pend <= 1'b0; div_busy <= 1'b1; busy_cnt <= 8;
      end else if (busy_cnt > 0) begin
         busy_cnt <= busy_cnt - 1;
         if (busy_cnt == 1) begin
            div_busy <= 1'b0;
            div_z <= ref_div(1'b0, lx, ly).z;
            div_r <= ref_div(1'b0, lx, ly).r;
         end
      end
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (div_start) starts <= starts + 1;
   end

   // scoreboard: push on accept, pop and compare on response handshake
   always @(negedge clk) begin
      if (!rstn) sbq.delete();
      else begin
         if (req0_valid && req0_ready) begin sbq.push_back(ref_div(1'b0, req0_x, req0_y)); grants.push_back(1'b0); end
         if (req1_valid && req1_ready) begin sbq.push_back(ref_div(1'b1, req1_x, req1_y)); grants.push_back(1'b1); end
         if (rsp_valid && rsp_ready) begin
            if (sbq.size() == 0) chk("sb_unexpected_rsp", {rsp_id, rsp_z, rsp_r, rsp_err}, 18'h3FFFF);
            else chk("sb_rsp", {rsp_id, rsp_z, rsp_r, rsp_err}, sbq.pop_front());
         end
      end
   end

   task automatic send(input bit id, input logic [7:0] x, input logic [7:0] y, output int t_acc);
      bit done = 1'b0;
      if (id) begin req1_valid = 1'b1; req1_x = x; req1_y = y; end
      else    begin req0_valid = 1'b1; req0_x = x; req0_y = y; end
      for (int n = 0; n < 200 && !done; n++) begin
         @(negedge clk);
         if (id ? req1_ready : req0_ready) done = 1'b1;
      end
      @(posedge clk); #1;
      t_acc = cyc;
      if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
      chk("accept", done, 1'b1);
   endtask

   task automatic wait_rsp(output rsp_t got, output int t_rsp);
      bit ok = 1'b0;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge clk);
         if (rsp_valid) ok = 1'b1;
      end
      got.id = rsp_id; got.z = rsp_z; got.r = rsp_r; got.err = rsp_err;
      t_rsp = cyc;
      chk("rsp_timeout", ok, 1'b1);
   endtask

   initial begin
      vec_t vt[8];
      rsp_t got, snap;
      int   ta, tr, s0, g0;
      bit   stable, ok;

      #200000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1);
   end

   initial begin
      vec_t vt[8];
      rsp_t got, snap;
      int   ta, tr, s0, g0;
      bit   stable, ok;

      vt[0] = '{1'b0, 8'h0D, 8'h03, 8'h04, 8'h01, 1'b0};
      vt[1] = '{1'b1, 8'h8D, 8'h03, 8'h84, 8'h81, 1'b0};
      vt[2] = '{1'b0, 8'h85, 8'h80, 8'h7F, 8'h85, 1'b1};
      vt[3] = '{1'b1, 8'h0D, 8'h00, 8'h7F, 8'h0D, 1'b1};
      vt[4] = '{1'b0, 8'h0D, 8'h83, 8'h84, 8'h01, 1'b0};
      vt[5] = '{1'b1, 8'h7F, 8'h01, 8'h7F, 8'h00, 1'b0};
      vt[6] = '{1'b0, 8'h05, 8'h09, 8'h00, 8'h05, 1'b0};
      vt[7] = '{1'b1, 8'h80, 8'h05, 8'h80, 8'h80, 1'b0};

      rstn = 1'b0; rsp_ready = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_x = 8'h00; req0_y = 8'h00; req1_x = 8'h00; req1_y = 8'h00;
      #2;
      chk("reset_outputs", {req0_ready, req1_ready, div_start, div_x, div_y, rsp_valid, rsp_id, rsp_z, rsp_r, rsp_err}, 0);
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      chk("reset_tie_ready", {req0_ready, req1_ready}, 2'b10);
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;

      // table: one request at a time, checked against constants, latency and start count
      foreach (vt[i]) begin
         s0 = starts;
         send(vt[i].id, vt[i].x, vt[i].y, ta);
         wait_rsp(got, tr);
         chk($sformatf("vec%0d_rsp", i), got, {vt[i].id, vt[i].z, vt[i].r, vt[i].err});
         chk($sformatf("vec%0d_latency", i), tr - ta, vt[i].err ? 0 : 10);
         chk($sformatf("vec%0d_starts", i), starts - s0, vt[i].err ? 0 : 1);
         @(posedge clk); #1;
      end

      // busy rises one cycle late: the initial low must not be taken as completion
      late = 1'b1;
      send(1'b0, 8'h2A, 8'h05, ta);
      wait_rsp(got, tr);
      chk("late_busy_rsp", got, {1'b0, 8'h08, 8'h02, 1'b0});
      chk("late_busy_latency", tr - ta, 11);
      @(posedge clk); #1;
      late = 1'b0;

      // both requesters valid continuously: grants alternate starting from the pointer state
      g0 = grants.size();
      req0_valid = 1'b1; req0_x = 8'h10; req0_y = 8'h04;
      req1_valid = 1'b1; req1_x = 8'h10; req1_y = 8'h04;
      for (int n = 0; n < 2000 && grants.size() < g0 + 8; n++) begin @(negedge clk); #1; end
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      ok = 1'b0;
      for (int n = 0; n < 200 && !ok; n++) begin @(negedge clk); #1; if (sbq.size() == 0) ok = 1'b1; end
      chk("rr_drain", ok, 1'b1);
      chk("rr_count", grants.size() - g0, 8);
      for (int i = 0; i < 8 && g0 + i < grants.size(); i++)
         chk($sformatf("rr_grant%0d", i), grants[g0 + i], grants[g0] ^ i[0]);
      @(posedge clk); #1;

      // backpressure with a competing request pending
      rsp_ready = 1'b0;
      send(1'b1, 8'h64, 8'h0A, ta);
      req0_valid = 1'b1; req0_x = 8'h09; req0_y = 8'h02;
      wait_rsp(snap, tr);
      chk("bp_rsp", snap, {1'b1, 8'h0A, 8'h00, 1'b0});
      stable = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (!rsp_valid || {rsp_id, rsp_z, rsp_r, rsp_err} !== snap || req0_ready || req1_ready) stable = 1'b0;
      end
      chk("bp_stable", stable, 1'b1);
      @(posedge clk); #1 rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_accept_after_ack", req0_ready, 1'b1);
      @(posedge clk); #1 req0_valid = 1'b0;
      wait_rsp(got, tr);
      chk("bp_next_rsp", got, {1'b0, 8'h04, 8'h01, 1'b0});
      @(posedge clk); #1;

      // reset while waiting on the divider; pointer returns to requester 0
      send(1'b0, 8'h0D, 8'h03, ta);
      repeat (3) @(posedge clk);
      #1 rstn = 1'b0;
      #1;
      chk("midreset_outputs", {req0_ready, req1_ready, div_start, div_x, div_y, rsp_valid, rsp_id, rsp_z, rsp_r, rsp_err}, 0);
      @(posedge clk); #1 rstn = 1'b1;
      g0 = grants.size();
      req0_valid = 1'b1; req0_x = 8'h10; req0_y = 8'h04;
      req1_valid = 1'b1; req1_x = 8'h10; req1_y = 8'h04;
      @(negedge clk);
      chk("midreset_tie", {req0_ready, req1_ready}, 2'b10);
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      wait_rsp(got, tr);
      chk("midreset_rsp", got, {1'b0, 8'h04, 8'h00, 1'b0});
      @(posedge clk); #1;
      repeat (2) @(posedge clk);
      chk("sb_empty", sbq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
